// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a first-word-fall-through FIFO and sends
// start, 8 data bits LSB first, parity and one stop bit per frame.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter bit          ODD_PARITY   = 1'b1
) (
    input  logic       tx_sclk_i,
    input  logic       tx_rst_i,
    input  logic [7:0] rdata_i,
    input  logic       rempty_i,
    output logic       rinc_o,
    output logic       tx_data_o,
    output logic       tx_busy_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par;
    logic             bit_end;
    logic             load;

    function automatic logic parity_of(input logic [7:0] d);
        return ODD_PARITY ? ~^d : ^d;
    endfunction

    assign bit_end = (cnt == CNT_LAST);

    // Pop is qualified directly by rempty_i so it can never fire against an empty FIFO
    assign load   = ~tx_rst_i & ~rempty_i & ((state == IDLE) | ((state == STOP) & bit_end));
    assign rinc_o = load;

    always_ff @(posedge tx_sclk_i or posedge tx_rst_i) begin
        if (tx_rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tx_data_o <= 1'b1;
            tx_busy_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (load) begin
                        state     <= START;
                        shreg     <= rdata_i;
                        par       <= parity_of(rdata_i);
                        tx_data_o <= 1'b0;
                        tx_busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        cnt       <= '0;
                        tx_data_o <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state     <= PARITY;
                            tx_data_o <= par;
                        end else begin
                            shreg     <= {1'b0, shreg[7:1]};
                            tx_data_o <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state     <= STOP;
                        cnt       <= '0;
                        tx_data_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        // Next byte waiting: go straight to a new start bit, no idle gap
                        if (load) begin
                            state     <= START;
                            shreg     <= rdata_i;
                            par       <= parity_of(rdata_i);
                            tx_data_o <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            tx_data_o <= 1'b1;
                            tx_busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    tx_data_o <= 1'b1;
                    tx_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8 clk/bit odd, 8 clk/bit even, 2 clk/bit odd)
// fed from bench FIFO models; line history is recorded per cycle and decoded afterwards.
module tb_uart_tx;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rdata0 = 8'h00;
    logic [7:0] rdata1 = 8'h00;
    logic [7:0] rdata2 = 8'h00;
    logic [2:0] rempty = 3'b111;
    logic       rinc_0, rinc_1, rinc_2;
    logic       txd_0, txd_1, txd_2;
    logic       busy_0, busy_1, busy_2;
    logic [2:0] rinc, txd, busy;

    assign rinc = {rinc_2, rinc_1, rinc_0};
    assign txd  = {txd_2, txd_1, txd_0};
    assign busy = {busy_2, busy_1, busy_0};

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [2:0] pend = 3'b000;
    logic       tog_en = 1'b0;
    int         cyc = 0;
    logic [2:0] tx_h    [MAXC];
    logic [2:0] busy_h  [MAXC];
    logic [2:0] rinc_h  [MAXC];
    logic [2:0] empty_h [MAXC];

    int checks = 0;
    int failures = 0;

    uart_tx #(.CLKS_PER_BIT(8), .ODD_PARITY(1'b1)) dut0 (
        .tx_sclk_i(clk), .tx_rst_i(rst), .rdata_i(rdata0), .rempty_i(rempty[0]),
        .rinc_o(rinc_0), .tx_data_o(txd_0), .tx_busy_o(busy_0));

    uart_tx #(.CLKS_PER_BIT(8), .ODD_PARITY(1'b0)) dut1 (
        .tx_sclk_i(clk), .tx_rst_i(rst), .rdata_i(rdata1), .rempty_i(rempty[1]),
        .rinc_o(rinc_1), .tx_data_o(txd_1), .tx_busy_o(busy_1));

    uart_tx #(.CLKS_PER_BIT(2), .ODD_PARITY(1'b1)) dut2 (
        .tx_sclk_i(clk), .tx_rst_i(rst), .rdata_i(rdata2), .rempty_i(rempty[2]),
        .rinc_o(rinc_2), .tx_data_o(txd_2), .tx_busy_o(busy_2));

    // FIFO models: pop after a strobed cycle, present the head, then record outputs
    always @(negedge clk) begin
        if (pend[0] && q0.size() > 0) q0.delete(0);
        if (pend[1] && q1.size() > 0) q1.delete(0);
        if (pend[2] && q2.size() > 0) q2.delete(0);
        rdata0    = (q0.size() > 0) ? q0[0] : 8'h00;
        rdata1    = (q1.size() > 0) ? q1[0] : 8'h00;
        rdata2    = (q2.size() > 0) ? q2[0] : 8'h00;
        rempty[0] = (q0.size() == 0);
        rempty[1] = (q1.size() == 0);
        rempty[2] = (q2.size() == 0) | (tog_en & cyc[0]);
        #1;
        if (cyc < MAXC) begin
            tx_h[cyc]    = txd;
            busy_h[cyc]  = busy;
            rinc_h[cyc]  = rinc;
            empty_h[cyc] = rempty;
        end
        pend = rinc;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    function automatic int find_rinc(input int s, input int from);
        for (int c = (from < 0 ? 0 : from); c < cyc && c < MAXC; c++)
            if (rinc_h[c][s]) return c;
        return -1;
    endfunction

    function automatic int count_rinc(input int s, input int a, input int b);
        int n = 0;
        for (int c = a; c < b && c < MAXC; c++) if (c >= 0 && rinc_h[c][s]) n++;
        return n;
    endfunction

    function automatic int count_busy(input int s, input int a, input int b);
        int n = 0;
        for (int c = a; c < b && c < MAXC; c++) if (c >= 0 && busy_h[c][s]) n++;
        return n;
    endfunction

    function automatic int count_bad_rinc(input int s, input int a, input int b);
        int n = 0;
        for (int c = a; c < b && c < MAXC; c++) if (c >= 0 && rinc_h[c][s] && empty_h[c][s]) n++;
        return n;
    endfunction

    function automatic logic tx_at(input int s, input int c);
        if (c < 0 || c >= MAXC) return 1'bx;
        return tx_h[c][s];
    endfunction

    function automatic logic busy_at(input int s, input int c);
        if (c < 0 || c >= MAXC) return 1'bx;
        return busy_h[c][s];
    endfunction

    // {stable, bits[10:0]}: bit k sampled in frame bit period k, stable if held all n cycles
    function automatic logic [11:0] get_frame(input int s, input int r, input int n);
        logic [10:0] bits;
        logic        stable;
        int          c;
        bits   = '0;
        stable = 1'b1;
        if (r < 0) return 12'h000;
        for (int k = 0; k < 11; k++) begin
            c = r + 1 + k * n;
            if (c + n > MAXC) return 12'h000;
            bits[k] = tx_h[c][s];
            for (int j = 0; j < n; j++)
                if (tx_h[c + j][s] !== bits[k]) stable = 1'b0;
        end
        return {stable, bits};
    endfunction

    function automatic logic [11:0] exp_frame_odd(input logic [7:0] b);
        return {1'b1, 1'b1, ~^b, b, 1'b0};
    endfunction

    int c0, c1, r, r1, r2, r3;
    logic [7:0] rb [16];

    initial begin
        rst = 1'b1;
        #2;
        check("rst_tx", 32'(txd), 32'h7);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rinc", 32'(rinc), 32'h0);
        tick(3);
        rst = 1'b0;

        // Single byte A5 on the odd-parity instance
        c0 = cyc;
        q0.push_back(8'hA5);
        tick(100);
        r = find_rinc(0, c0);
        check("a5_rinc_count", count_rinc(0, c0, cyc), 1);
        check("a5_frame", 32'(get_frame(0, r, 8)), 32'hF4A);
        check("a5_busy_len", count_busy(0, c0, cyc), 88);
        check("a5_idle_at_pop", 32'(tx_at(0, r)), 32'h1);
        check("a5_busy_last", 32'(busy_at(0, r + 88)), 32'h1);
        check("a5_busy_after", 32'(busy_at(0, r + 89)), 32'h0);
        check("a5_line_after", 32'(tx_at(0, r + 89)), 32'h1);

        // Three queued bytes back to back
        c0 = cyc;
        q0.push_back(8'h00);
        q0.push_back(8'hFF);
        q0.push_back(8'h3C);
        tick(3 * 88 + 20);
        r1 = find_rinc(0, c0);
        r2 = find_rinc(0, r1 + 1);
        r3 = find_rinc(0, r2 + 1);
        check("b2b_rinc_count", count_rinc(0, c0, cyc), 3);
        check("b2b_period1", r2 - r1, 88);
        check("b2b_period2", r3 - r2, 88);
        check("b2b_frame_00", 32'(get_frame(0, r1, 8)), 32'hE00);
        check("b2b_frame_ff", 32'(get_frame(0, r2, 8)), 32'hFFE);
        check("b2b_frame_3c", 32'(get_frame(0, r3, 8)), 32'hE78);
        check("b2b_busy_len", count_busy(0, c0, cyc), 264);
        check("b2b_busy_at_pop2", 32'(busy_at(0, r2)), 32'h1);

        // Even parity instance
        c0 = cyc;
        q1.push_back(8'h01);
        q1.push_back(8'h03);
        tick(2 * 88 + 20);
        r1 = find_rinc(1, c0);
        r2 = find_rinc(1, r1 + 1);
        check("even_rinc_count", count_rinc(1, c0, cyc), 2);
        check("even_frame_01", 32'(get_frame(1, r1, 8)), 32'hE02);
        check("even_frame_03", 32'(get_frame(1, r2, 8)), 32'hC06);

        // Reset in the middle of data bit d3 of 5A
        c0 = cyc;
        q0.push_back(8'h5A);
        tick(2);
        r = find_rinc(0, c0);
        while (cyc <= r + 36 && cyc < c0 + 200) tick(1);
        check("pre_rst_busy", 32'(busy[0]), 32'h1);
        check("pre_rst_d3", 32'(txd[0]), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(txd[0]), 32'h1);
        check("mid_rst_busy", 32'(busy[0]), 32'h0);
        check("mid_rst_rinc", 32'(rinc[0]), 32'h0);
        tick(3);
        rst = 1'b0;
        c1 = cyc;
        tick(20);
        check("lost_byte_no_pop", count_rinc(0, c1, cyc), 0);
        check("lost_byte_idle", count_busy(0, c1, cyc), 0);
        c0 = cyc;
        q0.push_back(8'h5A);
        tick(100);
        r = find_rinc(0, c0);
        check("post_rst_rinc_count", count_rinc(0, c0, cyc), 1);
        check("post_rst_frame_5a", 32'(get_frame(0, r, 8)), 32'hEB4);

        // Two clocks per bit with rempty toggling every cycle
        tog_en = 1'b1;
        c0 = cyc;
        q2.push_back(8'h81);
        q2.push_back(8'h7E);
        tick(80);
        r1 = find_rinc(2, c0);
        r2 = find_rinc(2, r1 + 1);
        check("n2_rinc_count", count_rinc(2, c0, cyc), 2);
        check("n2_rinc_vs_empty", count_bad_rinc(2, c0, cyc), 0);
        check("n2_frame_81", 32'(get_frame(2, r1, 2)), 32'hF02);
        check("n2_frame_7e", 32'(get_frame(2, r2, 2)), 32'hEFC);
        check("n2_busy_len", count_busy(2, c0, cyc), 44);
        check("n2_period_min", 32'((r2 - r1) >= 22), 32'h1);
        tog_en = 1'b0;

        // Sixteen pseudo-random bytes decoded off the line
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            q0.push_back(rb[i]);
        end
        tick(16 * 88 + 20);
        check("rnd_rinc_count", count_rinc(0, c0, cyc), 16);
        r = c0 - 1;
        for (int i = 0; i < 16; i++) begin
            r = find_rinc(0, r + 1);
            check("rnd_frame", 32'(get_frame(0, r, 8)), 32'(exp_frame_odd(rb[i])));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8: tx_sclk_i cycles per serial bit, legal range 2..255.
REQ-002 The block SHALL have parameter ODD_PARITY, default 1: 1 selects odd parity, 0 selects even parity.
REQ-003 The block SHALL have port tx_sclk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port tx_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port rdata_i, input, 8 bits: the byte at the head of the transmit FIFO (first-word-fall-through), valid whenever rempty_i is 0.
REQ-006 The block SHALL have port rempty_i, input, 1 bit: transmit FIFO empty flag.
REQ-007 The block SHALL have port rinc_o, output, 1 bit: one-cycle FIFO read strobe that pops the head byte.
REQ-008 The block SHALL have port tx_data_o, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port tx_busy_o, output, 1 bit: high while a frame is on the line.

Function
REQ-010 Each frame SHALL be: start bit (0), then d0..d7 LSB first, then parity bit, then one stop bit (1); 11 bits total, each held exactly CLKS_PER_BIT cycles.
REQ-011 The parity bit SHALL be ~^data when ODD_PARITY=1 and ^data when ODD_PARITY=0.
REQ-012 The FSM SHALL have one-hot states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE with rempty_i=0, the block SHALL assert rinc_o for exactly that cycle, capture rdata_i into the shift register on that edge, and enter START.
REQ-014 A bit-period counter SHALL clear on each state entry and on each DATA bit boundary, and increment every cycle otherwise; it SHALL never exceed CLKS_PER_BIT-1.
REQ-015 START SHALL advance to DATA, DATA bit boundaries SHALL advance the shift, and PARITY SHALL advance to STOP, each when the counter equals CLKS_PER_BIT-1.
REQ-016 A 3-bit bit index SHALL count DATA bits 0..7; DATA SHALL exit to PARITY at the boundary of bit index 7, and the index SHALL wrap to 0.
REQ-017 On the last STOP cycle with rempty_i=0, the block SHALL pulse rinc_o, capture rdata_i, and enter START directly, giving back-to-back frames with no idle gap.
REQ-018 On the last STOP cycle with rempty_i=1, the block SHALL return to IDLE.
REQ-019 rempty_i and rdata_i SHALL be ignored in all cycles other than the IDLE cycle and the last STOP cycle.
REQ-020 rinc_o SHALL be asserted only in the cycles named in REQ-013 and REQ-017, and never while rempty_i=1.
REQ-021 tx_data_o SHALL be registered, changing only on tx_sclk_i edges, with zero combinational path from any input.
REQ-022 The first start-bit cycle SHALL appear on tx_data_o one cycle after the rinc_o cycle.
REQ-023 tx_busy_o SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 The frame period SHALL be exactly 11*CLKS_PER_BIT cycles, measured from rinc_o to rinc_o, for back-to-back frames.

Reset
REQ-025 While tx_rst_i=1 (immediately, without a clock edge): state=IDLE, tx_data_o=1, rinc_o=0, tx_busy_o=0, counter=0, bit index=0, shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, drive the line high at once, and never pop the FIFO; the aborted byte is lost.
REQ-027 After tx_rst_i deasserts, the first rinc_o SHALL occur no earlier than the first rising edge with tx_rst_i low and rempty_i=0.

Verification
REQ-028 Scenario: rdata_i=8'hA5, rempty_i low for one byte -> single rinc_o pulse; line 0,1,0,1,0,0,1,0,1,(parity 1),1, each bit 8 cycles; tx_busy_o high for 88 cycles.
REQ-029 Scenario: three queued bytes 8'h00, 8'hFF, 8'h3C -> rinc_o pulses 88 cycles apart; parity bits 1, 1, 1; no idle-high gap between stop bit and next start bit.
REQ-030 Scenario: ODD_PARITY=0, byte 8'h01 -> parity bit 1; byte 8'h03 -> parity bit 0.
REQ-031 Scenario: tx_rst_i pulsed at the 4th DATA bit of 8'h5A -> tx_data_o=1 and tx_busy_o=0 asynchronously; next frame after release starts with a fresh start bit and full 11-bit frame.
REQ-032 Scenario: CLKS_PER_BIT=2, rempty_i toggling every cycle -> rinc_o only in the IDLE cycle or last STOP cycle when rempty_i=0; frame length 22 cycles.
REQ-033 Scenario: loopback of tx_data_o into the existing receiver (8 cycles/bit), 256 random bytes -> every received byte matches the sent byte and the parity-error bit is 0.
